seven_segment_bus_writer: RTL and testbench
===========================================

Name: seven_segment_bus_writer

Overview:
- Bus master that turns a 16-bit hex value into four single-word write transactions to the seven-segment peripheral's digit registers.
- Sits beside the CPU on the shared bus, behind the bus arbiter (request/grant).
- Converts nibbles to segment patterns internally.
- Coalesces updates that arrive while a write sequence is running, so the display always converges to the latest value.

Parameters:
- segmentBaseAddress, 32'h50000080: base address of the seven-segment peripheral. Digit i is written at segmentBaseAddress + 4*i, for i = 0..3.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- updateValid  in  1  one-cycle strobe; accepts updateValue and dpMask
- updateValue  in  16  hex value; digit i shows nibble updateValue[15-4i:12-4i]
- dpMask  in  4  bit i sets the decimal point (bit 7) of digit i
- busyOut  out  1  high while a sequence is running or an update is pending
- errorFlag  out  1  sticky; set on busErrorIn; cleared by reset or an accepted updateValid
- requestTransaction  out  1  bus request to the arbiter
- transactionGranted  in  1  arbiter grant
- beginTransactionOut  out  1  address phase strobe
- addressDataOut  out  32  address or data; 0 when not driving
- readNotWriteOut  out  1  always 0 while driving, else 0
- byteEnablesOut  out  4  4'hF in the begin cycle, else 0
- burstSizeOut  out  8  always 8'd0
- dataValidOut  out  1  write data valid
- endTransactionOut  out  1  end-of-transaction strobe
- busyIn  in  1  slave stall; data phase is held while high
- busErrorIn  in  1  slave error

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset value of every output is 0.
  - Bus outputs are 0 whenever the block is not the active master (wired-OR bus).
- Segment encoding:
  - Bits a..g map to bits 0..6; dp is bit 7.
  - Nibble 0..F encodes to: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
  - Data word = {24'd0, dp, pattern}.
- Value/pending registers:
  - updateValid in IDLE latches value and mask into the working register.
  - updateValid during a sequence latches into a single pending slot and sets pendingFlag. A newer strobe overwrites the slot; only the last value is kept.
  - Accepted updateValid clears errorFlag.
- FSM: IDLE, REQUEST, BEGIN, DATA, END, NEXT.
  - IDLE: if updateValid or pendingFlag, go to REQUEST with digit counter = 0. Pending moves into the working register and pendingFlag clears.
  - REQUEST: requestTransaction = 1. On transactionGranted, go to BEGIN.
  - BEGIN (1 cycle): beginTransactionOut = 1, addressDataOut = base + 4*digit, byteEnablesOut = F, readNotWriteOut = 0.
  - DATA: dataValidOut = 1, addressDataOut = data word. Held unchanged while busyIn = 1. Leave on the first cycle with busyIn = 0.
  - END (1 cycle): endTransactionOut = 1.
  - NEXT: if digit = 3, go to IDLE and drop requestTransaction; else digit + 1 and go to BEGIN.
  - requestTransaction stays high from REQUEST through the last END, so the grant is held for all four writes.
- Timing:
  - Nominal latency from grant to last endTransactionOut with no stalls: 4 × (BEGIN + DATA + END + NEXT) − 1 = 15 cycles.
  - updateValid in IDLE produces REQUEST on the next cycle.
- Error handling: busErrorIn in BEGIN or DATA:
  - set errorFlag;
  - go to END (endTransactionOut pulse);
  - abort the remaining digits and return to IDLE, releasing the request.
  - A pending update still starts afterwards.
- Grant loss: transactionGranted is sampled only in REQUEST. Losing the grant mid-sequence is an arbiter protocol violation and is ignored.
- Reset mid-sequence: all bus outputs drop to 0 in the next cycle, the FSM goes to IDLE, and the pending slot, errorFlag and counter clear.
- busyOut = (state != IDLE) | pendingFlag.

Test Plan:
1. Reset, then updateValid with 16'h1234, dpMask 4'b0000, grant immediately, busyIn = 0 → writes to 0x50000080 / 84 / 88 / 8C with data 0x06, 0x5B, 0x4F, 0x66. endTransactionOut pulses 4 times. Request drops 15 cycles after grant. busyOut then falls.
2. Value 16'hABCD with dpMask 4'b0101, grant delayed 5 cycles → REQUEST held 5 cycles, no begin before grant. Data 0xF7, 0x7C, 0xB9, 0x5E.
3. busyIn held high 3 cycles during digit 1's data phase → dataValidOut and data 0x5B stay stable 4 cycles; sequence completes 3 cycles later.
4. During a sequence for 16'h1111, strobe 16'h2222 then 16'h3333 → exactly one further sequence follows, writing pattern 0x4F ×4. 16'h2222 is never written.
5. busErrorIn during digit 2's data phase → endTransactionOut pulses, errorFlag = 1, no write to offset 0xC. The next updateValid clears errorFlag.
6. Reset asserted in DATA of digit 1 → all bus outputs are 0 next cycle, the FSM is in IDLE, and busyOut = 0.

Source files
------------

// File: rtl/seven_segment_bus_writer_if.sv
// Shared-bus signal bundle seen by the seven-segment bus writer.
//
// The master modport is the writer's view: it drives the request and all
// transaction outputs, and it observes the arbiter grant plus the slave's
// stall and error lines. The slave modport is the mirror view, used by
// whatever sits on the far side (arbiter/peripheral or a testbench).
//
// Signals:
//   requestTransaction   master -> arbiter   bus request
//   transactionGranted   arbiter -> master   grant
//   beginTransactionOut  master -> slave     address phase strobe
//   addressDataOut       master -> slave     address or write data, 0 when idle
//   readNotWriteOut      master -> slave     always 0 (write only)
//   byteEnablesOut       master -> slave     4'hF during the begin cycle
//   burstSizeOut         master -> slave     always 0 (single word)
//   dataValidOut         master -> slave     write data valid
//   endTransactionOut    master -> slave     end-of-transaction strobe
//   busyIn               slave -> master     stall, holds the data phase
//   busErrorIn           slave -> master     transaction error
interface seven_segment_bus_writer_if;
  logic        requestTransaction;
  logic        transactionGranted;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic        readNotWriteOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busyIn;
  logic        busErrorIn;

  modport master (
    output requestTransaction,
    output beginTransactionOut,
    output addressDataOut,
    output readNotWriteOut,
    output byteEnablesOut,
    output burstSizeOut,
    output dataValidOut,
    output endTransactionOut,
    input  transactionGranted,
    input  busyIn,
    input  busErrorIn
  );

  modport slave (
    input  requestTransaction,
    input  beginTransactionOut,
    input  addressDataOut,
    input  readNotWriteOut,
    input  byteEnablesOut,
    input  burstSizeOut,
    input  dataValidOut,
    input  endTransactionOut,
    output transactionGranted,
    output busyIn,
    output busErrorIn
  );
endinterface

// File: rtl/seven_segment_bus_writer.sv
// Bus master that pushes a 16-bit hex value onto the seven-segment display.
//
// Each update becomes four single-word writes, digit i going to
// segmentBaseAddress + 4*i with data {24'd0, dp, segments}. Updates that
// arrive while a sequence is running are coalesced into one pending slot,
// so the display always ends up showing the most recent value.
//
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   updateValid  one-cycle strobe accepting updateValue/dpMask
//   updateValue  hex value, digit i shows updateValue[15-4i:12-4i]
//   dpMask       bit i lights the decimal point of digit i
//   busyOut      sequence running or update pending
//   errorFlag    sticky bus error, cleared by reset or a new update
//   bus          master side of the shared bus (request/grant + transaction)
module seven_segment_bus_writer #(
  parameter logic [31:0] segmentBaseAddress = 32'h50000080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        updateValid,
  input  logic [15:0] updateValue,
  input  logic [3:0]  dpMask,
  output logic        busyOut,
  output logic        errorFlag,
  seven_segment_bus_writer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle, StRequest, StBegin, StData, StEnd, StNext
  } WriterState;

  WriterState  state, nextState;
  logic [1:0]  digit, nextDigit;
  logic        abortFlag, nextAbort;
  logic [15:0] workValue, nextWorkValue, pendValue, nextPendValue;
  logic [3:0]  workMask, nextWorkMask, pendMask, nextPendMask;
  logic        pendingFlag, nextPending;
  logic        nextError, nextBusy;

  logic        reqReg, beginReg, dataValidReg, endReg;
  logic [31:0] addrDataReg;
  logic [3:0]  byteEnReg;
  logic        nextReq, nextBegin, nextDataValid, nextEnd;
  logic [31:0] nextAddrData;
  logic [3:0]  nextByteEn;

  function automatic logic [6:0] segmentPattern(input logic [3:0] nibble);
    case (nibble)
      4'h0: segmentPattern = 7'h3F;
      4'h1: segmentPattern = 7'h06;
      4'h2: segmentPattern = 7'h5B;
      4'h3: segmentPattern = 7'h4F;
      4'h4: segmentPattern = 7'h66;
      4'h5: segmentPattern = 7'h6D;
      4'h6: segmentPattern = 7'h7D;
      4'h7: segmentPattern = 7'h07;
      4'h8: segmentPattern = 7'h7F;
      4'h9: segmentPattern = 7'h6F;
      4'hA: segmentPattern = 7'h77;
      4'hB: segmentPattern = 7'h7C;
      4'hC: segmentPattern = 7'h39;
      4'hD: segmentPattern = 7'h5E;
      4'hE: segmentPattern = 7'h79;
      default: segmentPattern = 7'h71;
    endcase
  endfunction

  // Digit 0 is the most significant nibble but uses dpMask bit 0.
  function automatic logic [31:0] dataWord(input logic [15:0] value,
                                           input logic [3:0] mask,
                                           input logic [1:0] idx);
    logic [3:0] nibble;
    case (idx)
      2'd0: nibble = value[15:12];
      2'd1: nibble = value[11:8];
      2'd2: nibble = value[7:4];
      default: nibble = value[3:0];
    endcase
    dataWord = {24'd0, mask[idx], segmentPattern(nibble)};
  endfunction

  // Next-state logic, plus the value of every output for the next cycle.
  // Outputs are decoded from the next state so that they can be registered
  // and still line up with the state the FSM is actually in.
  always_comb begin
    nextState     = state;
    nextDigit     = digit;
    nextAbort     = abortFlag;
    nextWorkValue = workValue;
    nextWorkMask  = workMask;
    nextPendValue = pendValue;
    nextPendMask  = pendMask;
    nextPending   = pendingFlag;
    nextError     = errorFlag;

    if (updateValid) begin
      nextError = 1'b0;
    end

    case (state)
      StIdle: begin
        // A fresh strobe is newer than anything in the pending slot.
        if (updateValid) begin
          nextWorkValue = updateValue;
          nextWorkMask  = dpMask;
        end else if (pendingFlag) begin
          nextWorkValue = pendValue;
          nextWorkMask  = pendMask;
        end
        if (updateValid || pendingFlag) begin
          nextPending = 1'b0;
          nextDigit   = 2'd0;
          nextAbort   = 1'b0;
          nextState   = StRequest;
        end
      end
      StRequest: begin
        if (bus.transactionGranted) begin
          nextState = StBegin;
        end
      end
      StBegin: begin
        if (bus.busErrorIn) begin
          nextError = 1'b1;
          nextAbort = 1'b1;
          nextState = StEnd;
        end else begin
          nextState = StData;
        end
      end
      StData: begin
        if (bus.busErrorIn) begin
          nextError = 1'b1;
          nextAbort = 1'b1;
          nextState = StEnd;
        end else if (!bus.busyIn) begin
          nextState = StEnd;
        end
      end
      StEnd: begin
        nextState = StNext;
      end
      StNext: begin
        if (digit == 2'd3 || abortFlag) begin
          nextState = StIdle;
        end else begin
          nextDigit = digit + 2'd1;
          nextState = StBegin;
        end
      end
      default: begin
        nextState = StIdle;
      end
    endcase

    if (state != StIdle && updateValid) begin
      nextPendValue = updateValue;
      nextPendMask  = dpMask;
      nextPending   = 1'b1;
    end

    nextReq       = 1'b0;
    nextBegin     = 1'b0;
    nextDataValid = 1'b0;
    nextEnd       = 1'b0;
    nextAddrData  = 32'd0;
    nextByteEn    = 4'd0;

    // The grant is held from REQUEST through the final END; the closing
    // NEXT cycle already releases it.
    case (nextState)
      StRequest: nextReq = 1'b1;
      StBegin: begin
        nextReq      = 1'b1;
        nextBegin    = 1'b1;
        nextAddrData = segmentBaseAddress + {28'd0, nextDigit, 2'b00};
        nextByteEn   = 4'hF;
      end
      StData: begin
        nextReq       = 1'b1;
        nextDataValid = 1'b1;
        nextAddrData  = dataWord(nextWorkValue, nextWorkMask, nextDigit);
      end
      StEnd: begin
        nextReq = 1'b1;
        nextEnd = 1'b1;
      end
      StNext: nextReq = (nextDigit != 2'd3) && !nextAbort;
      default: nextReq = 1'b0;
    endcase

    nextBusy = (nextState != StIdle) || nextPending;
  end

  // State and output registers; reset clears everything including the
  // pending slot and the sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      digit        <= 2'd0;
      abortFlag    <= 1'b0;
      workValue    <= 16'd0;
      workMask     <= 4'd0;
      pendValue    <= 16'd0;
      pendMask     <= 4'd0;
      pendingFlag  <= 1'b0;
      errorFlag    <= 1'b0;
      busyOut      <= 1'b0;
      reqReg       <= 1'b0;
      beginReg     <= 1'b0;
      dataValidReg <= 1'b0;
      endReg       <= 1'b0;
      addrDataReg  <= 32'd0;
      byteEnReg    <= 4'd0;
    end else begin
      state        <= nextState;
      digit        <= nextDigit;
      abortFlag    <= nextAbort;
      workValue    <= nextWorkValue;
      workMask     <= nextWorkMask;
      pendValue    <= nextPendValue;
      pendMask     <= nextPendMask;
      pendingFlag  <= nextPending;
      errorFlag    <= nextError;
      busyOut      <= nextBusy;
      reqReg       <= nextReq;
      beginReg     <= nextBegin;
      dataValidReg <= nextDataValid;
      endReg       <= nextEnd;
      addrDataReg  <= nextAddrData;
      byteEnReg    <= nextByteEn;
    end
  end

  assign bus.requestTransaction  = reqReg;
  assign bus.beginTransactionOut = beginReg;
  assign bus.addressDataOut      = addrDataReg;
  assign bus.readNotWriteOut     = 1'b0;
  assign bus.byteEnablesOut      = byteEnReg;
  assign bus.burstSizeOut        = 8'd0;
  assign bus.dataValidOut        = dataValidReg;
  assign bus.endTransactionOut   = endReg;

endmodule

// File: tb/tb_seven_segment_bus_writer.sv
// Self-checking bench for seven_segment_bus_writer.
//
// A write-list model turns each value the display should receive into the
// four {address, data} pairs it implies; a negedge monitor checks every
// bus cycle against that list and records completed writes so the directed
// tests can also pin literal addresses and data.
module tb_seven_segment_bus_writer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } WriteRec;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        updateValid = 1'b0;
  logic [15:0] updateValue = 16'd0;
  logic [3:0]  dpMask = 4'd0;
  logic        busyOut;
  logic        errorFlag;

  seven_segment_bus_writer_if bus();

  seven_segment_bus_writer dut (
    .clock       (clock),
    .reset       (reset),
    .updateValid (updateValid),
    .updateValue (updateValue),
    .dpMask      (dpMask),
    .busyOut     (busyOut),
    .errorFlag   (errorFlag),
    .bus         (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails = 0;
  int reqCycles = 0;
  int endCount = 0;
  logic monitorOn = 1'b0;

  WriteRec expQ[$];
  WriteRec capQ[$];
  WriteRec cur;
  logic [31:0] capAddr = 32'd0;
  logic [31:0] capData = 32'd0;

  logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Model: the four writes a displayed value must produce.
  task automatic expectValue(input int value, input int mask);
    WriteRec w;
    for (int i = 0; i < 4; i++) begin
      int nib;
      nib = (value >> (12 - 4 * i)) & 15;
      w.addr = 32'h50000080 + 32'(4 * i);
      w.data = (((mask >> i) & 1) != 0 ? 32'h80 : 32'h0) | 32'(segTable[nib]);
      expQ.push_back(w);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic [3:0] mask);
    updateValue = value;
    dpMask = mask;
    updateValid = 1'b1;
    tick();
    updateValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busyOut !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("idleTimeout", 32'(busyOut), 32'd0);
  endtask

  task automatic waitBegin(input logic [31:0] addr);
    int n = 0;
    while (!(bus.beginTransactionOut === 1'b1 && bus.addressDataOut === addr) && n < 60) begin
      tick();
      n++;
    end
    checkOutput("beginTimeout", (n < 60) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Per-cycle bus checks against the write-list model.
  always @(negedge clock) begin
    if (monitorOn) begin
      if (bus.requestTransaction === 1'b1) reqCycles++;
      checkOutput("readNotWrite", 32'(bus.readNotWriteOut), 32'd0);
      checkOutput("burstSize", 32'(bus.burstSizeOut), 32'd0);
      checkOutput("byteEnables", 32'(bus.byteEnablesOut),
                  bus.beginTransactionOut === 1'b1 ? 32'hF : 32'h0);
      if (bus.beginTransactionOut === 1'b1) begin
        checkOutput("beginWithData", 32'(bus.dataValidOut), 32'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBegin", bus.addressDataOut, 32'd0);
        end else begin
          cur = expQ.pop_front();
          checkOutput("beginAddress", bus.addressDataOut, cur.addr);
        end
        capAddr = bus.addressDataOut;
      end else if (bus.dataValidOut === 1'b1) begin
        checkOutput("writeData", bus.addressDataOut, cur.data);
        capData = bus.addressDataOut;
      end else begin
        checkOutput("idleBus", bus.addressDataOut, 32'd0);
      end
      if (bus.endTransactionOut === 1'b1) begin
        endCount++;
        capQ.push_back('{capAddr, capData});
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.transactionGranted = 1'b1;
    bus.busyIn = 1'b0;
    bus.busErrorIn = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("resetBusy", 32'(busyOut), 32'd0);
    checkOutput("resetError", 32'(errorFlag), 32'd0);
    checkOutput("resetRequest", 32'(bus.requestTransaction), 32'd0);
    checkOutput("resetAddr", bus.addressDataOut, 32'd0);
    monitorOn = 1'b1;

    // Test 1: 1234, immediate grant
    $display("[TB] test 1: basic sequence");
    expectValue(32'h1234, 0);
    capQ.delete();
    reqCycles = 0;
    endCount = 0;
    applyStimulus(16'h1234, 4'b0000);
    checkOutput("t1RequestNext", 32'(bus.requestTransaction), 32'd1);
    checkOutput("t1BusyNext", 32'(busyOut), 32'd1);
    waitIdle();
    checkOutput("t1ReqCycles", 32'(reqCycles), 32'd16);
    checkOutput("t1Ends", 32'(endCount), 32'd4);
    checkOutput("t1Writes", 32'(capQ.size()), 32'd4);
    if (capQ.size() == 4) begin
      checkOutput("t1Addr0", capQ[0].addr, 32'h50000080);
      checkOutput("t1Data0", capQ[0].data, 32'h06);
      checkOutput("t1Data1", capQ[1].data, 32'h5B);
      checkOutput("t1Data2", capQ[2].data, 32'h4F);
      checkOutput("t1Addr3", capQ[3].addr, 32'h5000008C);
      checkOutput("t1Data3", capQ[3].data, 32'h66);
    end
    checkOutput("t1Drained", 32'(expQ.size()), 32'd0);

    // Test 2: ABCD with decimal points, grant delayed
    $display("[TB] test 2: delayed grant");
    bus.transactionGranted = 1'b0;
    expectValue(32'hABCD, 32'b0101);
    capQ.delete();
    reqCycles = 0;
    applyStimulus(16'hABCD, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2ReqHeld", 32'(bus.requestTransaction), 32'd1);
      checkOutput("t2NoBegin", 32'(bus.beginTransactionOut), 32'd0);
      tick();
    end
    bus.transactionGranted = 1'b1;
    waitIdle();
    checkOutput("t2ReqCycles", 32'(reqCycles), 32'd21);
    if (capQ.size() == 4) begin
      checkOutput("t2Data0", capQ[0].data, 32'hF7);
      checkOutput("t2Data1", capQ[1].data, 32'h7C);
      checkOutput("t2Data2", capQ[2].data, 32'hB9);
      checkOutput("t2Data3", capQ[3].data, 32'h5E);
    end else begin
      checkOutput("t2Writes", 32'(capQ.size()), 32'd4);
    end
    checkOutput("t2Drained", 32'(expQ.size()), 32'd0);

    // Test 3: slave stall during digit 1 data
    $display("[TB] test 3: stall");
    expectValue(32'h1234, 0);
    reqCycles = 0;
    applyStimulus(16'h1234, 4'b0000);
    waitBegin(32'h50000084);
    bus.busyIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t3DataValidHeld", 32'(bus.dataValidOut), 32'd1);
      checkOutput("t3DataHeld", bus.addressDataOut, 32'h5B);
    end
    bus.busyIn = 1'b0;
    waitIdle();
    checkOutput("t3ReqCycles", 32'(reqCycles), 32'd19);
    checkOutput("t3Drained", 32'(expQ.size()), 32'd0);

    // Test 4: coalescing of updates during a sequence
    $display("[TB] test 4: coalescing");
    expectValue(32'h1111, 0);
    expectValue(32'h3333, 0);
    capQ.delete();
    reqCycles = 0;
    applyStimulus(16'h1111, 4'b0000);
    tick();
    tick();
    tick();
    applyStimulus(16'h2222, 4'b0000);
    tick();
    tick();
    applyStimulus(16'h3333, 4'b0000);
    checkOutput("t4BusyPending", 32'(busyOut), 32'd1);
    waitIdle();
    checkOutput("t4Writes", 32'(capQ.size()), 32'd8);
    checkOutput("t4ReqCycles", 32'(reqCycles), 32'd32);
    if (capQ.size() == 8) begin
      checkOutput("t4Data4", capQ[4].data, 32'h4F);
      checkOutput("t4Data7", capQ[7].data, 32'h4F);
    end
    checkOutput("t4Drained", 32'(expQ.size()), 32'd0);

    // Test 5: bus error during digit 2 data
    $display("[TB] test 5: bus error");
    expectValue(32'h5678, 0);
    capQ.delete();
    endCount = 0;
    applyStimulus(16'h5678, 4'b0000);
    waitBegin(32'h50000088);
    tick();
    checkOutput("t5InData", 32'(bus.dataValidOut), 32'd1);
    bus.busErrorIn = 1'b1;
    tick();
    bus.busErrorIn = 1'b0;
    checkOutput("t5EndPulse", 32'(bus.endTransactionOut), 32'd1);
    checkOutput("t5ErrorSet", 32'(errorFlag), 32'd1);
    waitIdle();
    checkOutput("t5ErrorSticky", 32'(errorFlag), 32'd1);
    checkOutput("t5Ends", 32'(endCount), 32'd3);
    checkOutput("t5Skipped", 32'(expQ.size()), 32'd1);
    expQ.delete();
    expectValue(32'h0000, 32'hF);
    capQ.delete();
    applyStimulus(16'h0000, 4'b1111);
    checkOutput("t5ErrorCleared", 32'(errorFlag), 32'd0);
    waitIdle();
    if (capQ.size() == 4) begin
      checkOutput("t5DpData", capQ[0].data, 32'hBF);
    end else begin
      checkOutput("t5Writes", 32'(capQ.size()), 32'd4);
    end
    checkOutput("t5Drained", 32'(expQ.size()), 32'd0);

    // Test 6: reset in the middle of digit 1 data
    $display("[TB] test 6: reset mid-sequence");
    expectValue(32'h9876, 0);
    applyStimulus(16'h9876, 4'b0000);
    waitBegin(32'h50000084);
    tick();
    checkOutput("t6DataBefore", bus.addressDataOut, 32'h7F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6Request", 32'(bus.requestTransaction), 32'd0);
    checkOutput("t6DataValid", 32'(bus.dataValidOut), 32'd0);
    checkOutput("t6Addr", bus.addressDataOut, 32'd0);
    checkOutput("t6End", 32'(bus.endTransactionOut), 32'd0);
    checkOutput("t6Busy", 32'(busyOut), 32'd0);
    checkOutput("t6Leftover", 32'(expQ.size()), 32'd2);
    expQ.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t6StaysIdle", 32'(busyOut), 32'd0);
    end

    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
